// File: rtl/switch_pkg.sv
// Shared types and constants for the switch bounce emulator.
package switch_pkg;

  typedef enum logic {STABLE, BOUNCE} bounce_state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 16-bit Galois LFSR; advances only when step is high, reloads SEED on reset.
module bounce_lfsr
  import switch_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/switch_bounce_gen.sv
// Contact-bounce emulator: turns a clean level into a reproducible bouncy
// waveform that settles on the clean level after a fixed tick window.
module switch_bounce_gen
  import switch_pkg::*;
#(
  parameter int          TICK_M       = 100000,
  parameter int          BOUNCE_TICKS = 8,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_clean,
  input  logic       bounce_en,
  output logic       sw_bouncy,
  output logic       busy,
  output logic [7:0] toggle_cnt
);

  localparam int                CNT_W     = (TICK_M > 1) ? $clog2(TICK_M) : 1;
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_M - 1);
  localparam logic [7:0]        LAST_IDX  = 8'(BOUNCE_TICKS - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  bounce_state_t    state, state_nxt;
  logic             tgt, tgt_nxt;
  logic             out_nxt;
  logic [7:0]       cnt_nxt;
  logic [CNT_W-1:0] tick_cnt, tick_cnt_nxt;
  logic [7:0]       tick_idx, tick_idx_nxt;
  logic             tick;
  logic             lfsr_step;
  logic [15:0]      lfsr;

  bounce_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (lfsr_step),
    .q    (lfsr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= STABLE;
      tgt        <= 1'b0;
      sw_bouncy  <= 1'b0;
      toggle_cnt <= 8'd0;
      tick_cnt   <= '0;
      tick_idx   <= 8'd0;
    end else begin
      state      <= state_nxt;
      tgt        <= tgt_nxt;
      sw_bouncy  <= out_nxt;
      toggle_cnt <= cnt_nxt;
      tick_cnt   <= tick_cnt_nxt;
      tick_idx   <= tick_idx_nxt;
    end
  end

  // A clean edge always (re)opens a window, even mid-bounce, so it is
  // checked ahead of the abort and tick handling.
  always_comb begin
    state_nxt    = state;
    tgt_nxt      = tgt;
    out_nxt      = sw_bouncy;
    cnt_nxt      = toggle_cnt;
    tick_cnt_nxt = tick_cnt;
    tick_idx_nxt = tick_idx;
    lfsr_step    = 1'b0;
    tick         = (tick_cnt == TICK_LAST);

    if (sw_clean != tgt) begin
      tgt_nxt      = sw_clean;
      out_nxt      = sw_clean;
      cnt_nxt      = 8'd1;
      tick_cnt_nxt = '0;
      tick_idx_nxt = 8'd0;
      state_nxt    = bounce_en ? BOUNCE : STABLE;
    end else if (state == BOUNCE) begin
      if (!bounce_en) begin
        out_nxt   = tgt;
        state_nxt = STABLE;
      end else if (tick) begin
        tick_cnt_nxt = '0;
        tick_idx_nxt = tick_idx + 8'd1;
        if (tick_idx != LAST_IDX) begin
          if (lfsr[0]) begin
            out_nxt = ~sw_bouncy;
            cnt_nxt = sat_inc(toggle_cnt);
          end
          lfsr_step = 1'b1;
        end else begin
          if (sw_bouncy != tgt) begin
            out_nxt = tgt;
            cnt_nxt = sat_inc(toggle_cnt);
          end
          state_nxt = STABLE;
        end
      end else begin
        tick_cnt_nxt = tick_cnt + CNT_W'(1);
      end
    end
  end

  assign busy = (state == BOUNCE);

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Directed bench for switch_bounce_gen with a window-age reference model.
module tb_switch_bounce_gen;

  localparam int M = 4;
  localparam int B = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_clean = 1'b0;
  logic       bounce_en = 1'b1;
  logic       sw_bouncy;
  logic       busy;
  logic [7:0] toggle_cnt;

  int n_chk = 0;
  int n_err = 0;

  switch_bounce_gen #(
    .TICK_M       (M),
    .BOUNCE_TICKS (B),
    .SEED         (16'hACE1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_clean   (sw_clean),
    .bounce_en  (bounce_en),
    .sw_bouncy  (sw_bouncy),
    .busy       (busy),
    .toggle_cnt (toggle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: window tracked by its age in cycles; tick n fires when
  // age reaches n*M.
  logic        m_tgt, m_out, m_win;
  int          m_cnt, m_age;
  logic [15:0] m_lfsr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tgt = 0; m_out = 0; m_win = 0; m_cnt = 0; m_age = 0; m_lfsr = 16'hACE1;
    end else if (sw_clean != m_tgt) begin
      m_tgt = sw_clean; m_out = sw_clean; m_cnt = 1; m_age = 0; m_win = bounce_en;
    end else if (m_win && !bounce_en) begin
      m_out = m_tgt; m_win = 0;
    end else if (m_win) begin
      m_age = m_age + 1;
      if (m_age % M == 0) begin
        if (m_age / M < B) begin
          if (m_lfsr[0]) begin
            m_out = !m_out;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          end
          m_lfsr = m_lfsr[0] ? ({1'b0, m_lfsr[15:1]} ^ 16'hB400) : {1'b0, m_lfsr[15:1]};
        end else begin
          if (m_out != m_tgt) begin
            m_out = m_tgt;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          end
          m_win = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_sw_bouncy", 16'(sw_bouncy), 16'(m_out));
    chk("model_busy", 16'(busy), 16'(m_win));
    chk("model_toggle_cnt", 16'(toggle_cnt), 16'(m_cnt));
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset held with sw_clean low
    adv(3);
    chk("rst_sw_bouncy", 16'(sw_bouncy), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_toggle_cnt", 16'(toggle_cnt), 16'd0);
    rst = 1'b0;
    adv(50);
    chk("idle_sw_bouncy", 16'(sw_bouncy), 16'd0);
    chk("idle_busy", 16'(busy), 16'd0);
    chk("idle_toggle_cnt", 16'(toggle_cnt), 16'd0);

    // Rising edge with bounce: LFSR ACE1 -> toggle on tick 1 only
    sw_clean = 1'b1;
    adv(1);
    chk("rise_k1_sw", 16'(sw_bouncy), 16'd1);
    chk("rise_k1_busy", 16'(busy), 16'd1);
    adv(4);
    chk("rise_k5_sw", 16'(sw_bouncy), 16'd0);
    adv(11);
    chk("rise_k16_sw", 16'(sw_bouncy), 16'd0);
    chk("rise_k16_busy", 16'(busy), 16'd1);
    adv(1);
    chk("rise_k17_sw", 16'(sw_bouncy), 16'd1);
    chk("rise_k17_busy", 16'(busy), 16'd0);
    chk("rise_k17_cnt", 16'(toggle_cnt), 16'd3);
    adv(3);

    // Pass-through: five clean toggles
    bounce_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sw_clean = ~sw_clean;
      adv(1);
      chk("pass_sw", 16'(sw_bouncy), 16'(sw_clean));
      chk("pass_busy", 16'(busy), 16'd0);
      chk("pass_cnt", 16'(toggle_cnt), 16'd1);
      adv(2);
    end

    // Restart: clean returns low at k+6; LFSR now 389C
    bounce_en = 1'b1;
    sw_clean = 1'b1;
    adv(6);
    sw_clean = 1'b0;
    adv(1);
    chk("restart_k7_sw", 16'(sw_bouncy), 16'd0);
    chk("restart_k7_busy", 16'(busy), 16'd1);
    chk("restart_k7_cnt", 16'(toggle_cnt), 16'd1);
    adv(8);
    chk("restart_k15_sw", 16'(sw_bouncy), 16'd1);
    adv(7);
    chk("restart_k22_busy", 16'(busy), 16'd1);
    adv(1);
    chk("restart_k23_busy", 16'(busy), 16'd0);
    chk("restart_k23_sw", 16'(sw_bouncy), 16'd0);
    chk("restart_k23_cnt", 16'(toggle_cnt), 16'd3);
    adv(2);

    // Abort: bounce_en drops mid-window
    sw_clean = 1'b1;
    adv(3);
    bounce_en = 1'b0;
    adv(1);
    chk("abort_sw", 16'(sw_bouncy), 16'd1);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_cnt", 16'(toggle_cnt), 16'd1);
    bounce_en = 1'b1;
    adv(5);
    chk("abort_stays_idle", 16'(busy), 16'd0);

    // Asynchronous reset mid-window, then release with sw_clean high
    sw_clean = 1'b0;
    adv(9);
    #2;
    rst = 1'b1;
    sw_clean = 1'b1;
    #1;
    chk("async_sw", 16'(sw_bouncy), 16'd0);
    chk("async_busy", 16'(busy), 16'd0);
    chk("async_cnt", 16'(toggle_cnt), 16'd0);
    adv(2);
    rst = 1'b0;
    adv(1);
    chk("rel_k1_sw", 16'(sw_bouncy), 16'd1);
    chk("rel_k1_busy", 16'(busy), 16'd1);
    adv(4);
    chk("rel_k5_sw_seed", 16'(sw_bouncy), 16'd0);
    adv(12);
    chk("rel_k17_sw", 16'(sw_bouncy), 16'd1);
    chk("rel_k17_busy", 16'(busy), 16'd0);
    chk("rel_k17_cnt", 16'(toggle_cnt), 16'd3);
    adv(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
